// File: rtl/sram_arbiter.sv
// sram_arbiter: merges the instruction and data sram-like ports into one
// master port. The data port has fixed priority. A lock holds the grant on a
// presented request until it is accepted. An in-order id queue routes each
// downstream data_ok back to the port that issued the request.
module sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    // instruction port
    input  logic                     inst_req,
    input  logic                     inst_wr,
    input  logic [1:0]               inst_size,
    input  logic [31:0]              inst_addr,
    input  logic [3:0]               inst_wstrb,
    input  logic [31:0]              inst_wdata,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [31:0]              inst_rdata,
    // data port
    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [1:0]               data_size,
    input  logic [31:0]              data_addr,
    input  logic [3:0]               data_wstrb,
    input  logic [31:0]              data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [31:0]              data_rdata,
    // merged master port
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [31:0]              mem_addr,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    // status
    output logic [$clog2(DEPTH):0]   pending_cnt,
    output logic                     protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // id encoding: 0 = instruction port, 1 = data port
    logic             lock_reg;
    logic             lock_id_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             err_reg;
    logic             id_q_reg [DEPTH];

    logic grant_id;
    logic grant_req;
    logic full;
    logic push;
    logic pop;
    logic head_id;

    // Grant selection: a locked grant wins, otherwise data beats inst.
    // With no requester the grant defaults to the data port so the
    // mem_* fields follow the data-side values.
    always_comb begin
        grant_id  = 1'b1;
        grant_req = 1'b0;
        if (lock_reg) begin
            grant_id  = lock_id_reg;
            grant_req = lock_id_reg ? data_req : inst_req;
        end else if (data_req) begin
            grant_id  = 1'b1;
            grant_req = 1'b1;
        end else if (inst_req) begin
            grant_id  = 1'b0;
            grant_req = 1'b1;
        end
    end

    // Full blocks new requests even when a pop happens in the same cycle.
    assign full    = (cnt_reg == CNT_W'(DEPTH));
    assign mem_req = grant_req & ~full & resetn;

    // Field mux from the granted port.
    always_comb begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
        if (!grant_id) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wstrb = inst_wstrb;
            mem_wdata = inst_wdata;
        end
    end

    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & ~grant_id;
    assign data_addr_ok = push & grant_id;

    // A completion only counts when something is outstanding; a stray
    // data_ok on an empty queue is flagged instead of popped.
    assign pop          = mem_data_ok & (cnt_reg != '0) & resetn;
    assign head_id      = id_q_reg[head_reg];
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign pending_cnt  = cnt_reg;
    assign protocol_err = err_reg;

    // Occupancy: push and pop together leave the count unchanged.
    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    // Id queue slots: each slot captures the granted id when the tail points at it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    id_q_reg[gi] <= 1'b0;
                end else if (push && (tail_reg == PTR_W'(gi))) begin
                    id_q_reg[gi] <= grant_id;
                end
            end
        end
    endgenerate

    // Queue pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            cnt_reg <= cnt_next;
        end
    end

    // Lock holds the grant while a presented request waits for addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_reg    <= 1'b0;
            lock_id_reg <= 1'b0;
        end else begin
            lock_reg <= mem_req & ~mem_addr_ok;
            if (mem_req && !mem_addr_ok) lock_id_reg <= grant_id;
        end
    end

    // Sticky error for a data_ok that has no outstanding request to match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_reg <= 1'b0;
        end else if (mem_data_ok && (cnt_reg == '0)) begin
            err_reg <= 1'b1;
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-into-one arbiter for the core's sram-like bus. It merges the instruction port (fetch) and the data port (load/store) from `cpu_core` into a single sram-like master port toward memory or the AXI bridge. Data requests get fixed priority. An in-order ID queue routes each `data_ok` back to the port that issued the request.

## Interface
- `DEPTH`, default 4: maximum number of outstanding accepted requests (≥2, power of two).
- `clk` input 1: clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `inst_req` input 1: instruction-side request, held until `inst_addr_ok`.
- `inst_wr`, `inst_size[1:0]`, `inst_addr[31:0]`, `inst_wstrb[3:0]`, `inst_wdata[31:0]` input: instruction-side request fields.
- `inst_addr_ok` output 1: instruction request accepted this cycle.
- `inst_data_ok` output 1: the oldest instruction-side request has completed.
- `inst_rdata` output 32: read data, valid when `inst_data_ok` is high.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wstrb[3:0]`, `data_wdata[31:0]` input: data-side request fields.
- `data_addr_ok`, `data_data_ok` output 1: data-side handshakes.
- `data_rdata` output 32: data-side read data.
- `mem_req` output 1: merged request.
- `mem_wr`, `mem_size[1:0]`, `mem_addr[31:0]`, `mem_wstrb[3:0]`, `mem_wdata[31:0]` output: fields of the granted port.
- `mem_addr_ok`, `mem_data_ok` input 1: downstream handshakes. Downstream returns `data_ok` strictly in acceptance order.
- `mem_rdata` input 32: downstream read data.
- `pending_cnt` output log2(DEPTH)+1: number of outstanding requests.
- `protocol_err` output 1: sticky flag, set on `mem_data_ok` while the queue is empty.

## Operation
- Grant selection:
  - If `lock` is set, grant goes to `lock_id`.
  - Otherwise, `data_req` wins over `inst_req`.
  - If neither port is requesting, there is no grant.
- Lock:
  - Set when `mem_req & ~mem_addr_ok`; `lock_id` records the granted port.
  - Cleared on the cycle `mem_addr_ok` is high.
  - Purpose: a request, once presented, is never swapped for the other port's request before acceptance.
- `mem_req` = (granted port's req) & ~full & resetn. `mem_*` fields mux from the granted port; with no grant, fields take data-port values.
- `X_addr_ok` = `mem_addr_ok` & `mem_req` & (grant == X). The non-granted port always sees 0.
- Accept (`mem_req & mem_addr_ok`): push the port id (0 = inst, 1 = data) at the queue tail.
- Completion (`mem_data_ok` with queue non-empty):
  - Pop the head.
  - Assert `X_data_ok` only for the head id.
  - `mem_rdata` is broadcast to both `inst_rdata` and `data_rdata`.
- Writes occupy a queue slot and receive `data_ok` the same way as reads.
- Full (`pending_cnt == DEPTH`):
  - `mem_req` = 0 and both `addr_ok` = 0, even if a pop occurs in the same cycle (no bypass).
  - Lock cannot coexist with full, because the count only rises on an accept.
- Simultaneous push and pop: head and tail both advance; `pending_cnt` is unchanged.
- Empty queue with `mem_data_ok` high: no `data_ok` on either port, no pop; `protocol_err` is set.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. The count is tracked separately to distinguish full from empty.

## Timing
- Request path (req → `mem_req`, `mem_addr_ok` → `X_addr_ok`) is combinational, 0 cycles.
- Response path (`mem_data_ok` → `X_data_ok`, rdata) is combinational from the queue head, 0 cycles.
- Queue, count, lock and err update on the `clk` rising edge. A request accepted in cycle N can complete in cycle N+1 at the earliest.
- Reset (asynchronous, `resetn` low), effective immediately:
  - Queue pointers, `pending_cnt`, `lock` and `protocol_err` clear to 0.
  - `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok` and `data_data_ok` are 0.
- Reset mid-operation: outstanding ids are discarded. A stale `mem_data_ok` arriving after reset sets `protocol_err`, so downstream must be reset together with this block.
- Reset release: arbitration is normal from the first rising edge.

## Test plan
- Single fetch: `inst_req` with addr 0x1C000000 and `mem_addr_ok` in the same cycle, then `mem_data_ok` with rdata 0x02800C0C one cycle later. Required: `inst_addr_ok` = 1 in cycle 0, `inst_data_ok` = 1 with rdata 0x02800C0C in cycle 1, `data_data_ok` = 0 throughout, `pending_cnt` 0→1→0.
- Conflict: `inst_req` and `data_req` (store, addr 0x8, wstrb 0xF) rise together with `mem_addr_ok` high. Required: data is granted first (`mem_wr` = 1, `mem_addr` 0x8); inst is granted the next cycle; `data_ok` returns route data first, then inst.
- Lock: inst presented with `mem_addr_ok` = 0 for 3 cycles, and `data_req` rises in cycle 1. Required: `mem_addr` stays the inst address until acceptance; data is granted the cycle after.
- Full: `DEPTH` = 4, accept 4 requests with no `data_ok`. Required: `pending_cnt` = 4 and `mem_req` = 0 while reqs are held. Then one `mem_data_ok` arrives: `mem_req` reasserts on the next cycle and the queue wraps correctly over a 10-request interleaved sequence.
- Same-cycle push and pop at `pending_cnt` = 2: count stays 2 and the routing order is preserved.
- Error and reset: `mem_data_ok` with the queue empty sets `protocol_err` and produces no port `data_ok`. Asserting `resetn` = 0 mid-burst, with 3 requests pending, clears the count and flag asynchronously and forces `mem_req` low.
